stack_mem_arbiter: RTL and testbench

Arbitrates the single-port data/instruction memory between two requesters: the multicycle CPU controller (port C) and the program loader/debug port (port L). It sequences each access through a fixed-latency memory using a req/ack handshake. It alternates grants round-robin when both ports request, and registers all memory-side outputs. It sits between the controller's MemRead/MemWrite path and the memory macro.

---
 rtl/stack_mem_pkg.sv | 17 +
 rtl/stack_mem_arbiter_if.sv | 44 ++++
 rtl/rr_pick2.sv | 28 ++
 rtl/stack_mem_arbiter.sv | 113 +++++++++++
 tb/tb_stack_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_mem_pkg.sv
// Shared definitions for the stack memory arbiter slice.
// Contents: FSM state encoding, requester port ids, wait-counter width.
package stack_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_L = 1'b1;

   // Wide enough for LAT-1 with LAT up to 15.
   localparam int unsigned CW = 4;

endpackage

// File: rtl/stack_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory macro.
// slave  : arbiter view (requester commands and mem_rdata in; acks, rdata, mem_*, busy out).
// master : environment view (requesters plus memory model), the mirror image.
interface stack_mem_arbiter_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 8
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_ack;
   logic          l_req;
   logic          l_we;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic          l_ack;
   logic [DW-1:0] rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  l_req, l_we, l_addr, l_wdata,
      input  mem_rdata,
      output c_ack, l_ack, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output l_req, l_we, l_addr, l_wdata,
      output mem_rdata,
      input  c_ack, l_ack, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-requester round-robin picker.
// i_req_c / i_req_l : requests from the CPU and loader ports
// i_last            : port granted most recently
// o_valid           : at least one request present
// o_winner          : granted port id (meaningful only when o_valid)
module rr_pick2
   import stack_mem_pkg::*;
(
   input  logic i_req_c,
   input  logic i_req_l,
   input  logic i_last,
   output logic o_valid,
   output logic o_winner
);

   always_comb begin
      o_valid = i_req_c | i_req_l;
      if (i_req_c && i_req_l) begin
         // Tie: hand the grant to whoever did not go last.
         o_winner = ~i_last;
      end else if (i_req_l) begin
         o_winner = PORT_L;
      end else begin
         o_winner = PORT_C;
      end
   end

endmodule

// File: rtl/stack_mem_arbiter.sv
// Arbitrates a single-port fixed-latency memory between the CPU (C) and loader (L) ports.
// clk, rst : clock, asynchronous active-high reset
// bus      : slave modport carrying both requester handshakes, shared rdata, the registered
//            mem_* command outputs, mem_rdata and busy.
// Each grant runs IDLE -> ACCESS (LAT cycles) -> DONE (ack pulse) -> IDLE.
module stack_mem_arbiter
   import stack_mem_pkg::*;
#(
   parameter int unsigned AW  = 5,
   parameter int unsigned DW  = 8,
   parameter int unsigned LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   stack_mem_arbiter_if.slave bus
);

   state_t        r_state, w_state_d;
   logic          r_last, w_last_d;
   logic [CW-1:0] r_cnt, w_cnt_d;
   logic          r_we, w_we_d;
   logic [AW-1:0] r_addr, w_addr_d;
   logic [DW-1:0] r_wdata, w_wdata_d;
   logic [DW-1:0] r_rdata, w_rdata_d;
   logic          r_mem_en, w_mem_en_d;
   logic          r_mem_we, w_mem_we_d;
   logic          w_valid;
   logic          w_winner;

   rr_pick2 u_pick (
      .i_req_c  (bus.c_req),
      .i_req_l  (bus.l_req),
      .i_last   (r_last),
      .o_valid  (w_valid),
      .o_winner (w_winner)
   );

   always_comb begin
      w_state_d = r_state;
      w_last_d  = r_last;
      w_cnt_d   = r_cnt;
      w_we_d    = r_we;
      w_addr_d  = r_addr;
      w_wdata_d = r_wdata;
      w_rdata_d = r_rdata;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_last_d  = w_winner;
               w_we_d    = (w_winner == PORT_L) ? bus.l_we    : bus.c_we;
               w_addr_d  = (w_winner == PORT_L) ? bus.l_addr  : bus.c_addr;
               w_wdata_d = (w_winner == PORT_L) ? bus.l_wdata : bus.c_wdata;
               w_cnt_d   = CW'(LAT - 1);
               w_state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               if (!r_we) begin
                  w_rdata_d = bus.mem_rdata;
               end
               w_state_d = DONE;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
      // Memory strobes are registered, so derive them from the state being entered.
      w_mem_en_d = (w_state_d == ACCESS);
      w_mem_we_d = w_mem_en_d & w_we_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= PORT_L;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_last   <= w_last_d;
         r_cnt    <= w_cnt_d;
         r_we     <= w_we_d;
         r_addr   <= w_addr_d;
         r_wdata  <= w_wdata_d;
         r_rdata  <= w_rdata_d;
         r_mem_en <= w_mem_en_d;
         r_mem_we <= w_mem_we_d;
      end
   end

   // Acks are Moore outputs: DONE plus the port recorded at grant time.
   assign bus.c_ack     = (r_state == DONE) && (r_last == PORT_C);
   assign bus.l_ack     = (r_state == DONE) && (r_last == PORT_L);
   assign bus.busy      = (r_state != IDLE);
   assign bus.rdata     = r_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Self-checking bench for stack_mem_arbiter (LAT = 3): directed scenarios with literal
// expectations, then randomized requesters, all compared every cycle against a
// transaction-level model.
module tb_stack_mem_arbiter;
   import stack_mem_pkg::*;

   localparam int unsigned AW  = 5;
   localparam int unsigned DW  = 8;
   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stack_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   stack_mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 3) ? 8'hA5 : 8'(i * 29 + 7);
   endfunction

   // Memory macro seen by the DUT; reset restores its contents so aborted writes do not matter.
   logic [DW-1:0] tb_mem [32];
   assign bus.mem_rdata = tb_mem[bus.mem_addr];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
      end else if (bus.mem_en && bus.mem_we) begin
         tb_mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   // Transaction-level model: m_phase counts cycles since the grant (0 = idle,
   // 1..LAT = memory access, LAT+1 = ack cycle).
   logic [DW-1:0] ref_mem [32];
   int unsigned   m_phase;
   logic          m_last, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic          m_win;
   assign m_win = (bus.c_req && bus.l_req) ? ~m_last : bus.l_req;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0;
         m_last  <= PORT_L;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_rdata <= '0;
         for (int i = 0; i < 32; i++) ref_mem[i] <= init_val(i);
      end else if (m_phase == 0) begin
         if (bus.c_req || bus.l_req) begin
            m_last  <= m_win;
            m_we    <= m_win ? bus.l_we    : bus.c_we;
            m_addr  <= m_win ? bus.l_addr  : bus.c_addr;
            m_wdata <= m_win ? bus.l_wdata : bus.c_wdata;
            m_phase <= 1;
         end
      end else if (m_phase <= LAT) begin
         if (m_phase == 1 && m_we) ref_mem[m_addr] <= m_wdata;
         if (m_phase == LAT && !m_we) m_rdata <= ref_mem[m_addr];
         m_phase <= m_phase + 1;
      end else begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("c_ack",     32'(bus.c_ack),  32'(m_phase == LAT + 1 && m_last == PORT_C));
         check("l_ack",     32'(bus.l_ack),  32'(m_phase == LAT + 1 && m_last == PORT_L));
         check("busy",      32'(bus.busy),   32'(m_phase != 0));
         check("mem_en",    32'(bus.mem_en), 32'(m_phase >= 1 && m_phase <= LAT));
         check("mem_we",    32'(bus.mem_we), 32'(m_phase >= 1 && m_phase <= LAT && m_we));
         check("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
         check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
         check("rdata",     32'(bus.rdata),     32'(m_rdata));
      end
   end

   task automatic drive(input logic port, input logic req, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port == PORT_L) begin
         bus.l_req = req; bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
      end else begin
         bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
      end
   endtask

   task automatic rand_cmd(input logic port);
      drive(port, 1'b1, 1'($urandom_range(1, 0)), AW'($urandom_range(7, 0)), DW'($urandom));
   endtask

   // Issue one transaction from an idle-cycle negedge; report latency in negedges to the ack.
   task automatic run_txn(input logic port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          output int lat, output int en_cyc, output int we_cyc,
                          output int other_ack);
      drive(port, 1'b1, we, a, d);
      lat = -1; en_cyc = 0; we_cyc = 0; other_ack = 0;
      for (int i = 1; i <= 30 && lat < 0; i++) begin
         @(negedge clk);
         if (bus.mem_en) en_cyc++;
         if (bus.mem_we) we_cyc++;
         if ((port == PORT_L) ? bus.c_ack : bus.l_ack) other_ack++;
         if ((port == PORT_L) ? bus.l_ack : bus.c_ack) lat = i;
      end
      if (port == PORT_L) bus.l_req = 1'b0;
      else bus.c_req = 1'b0;
   endtask

   int lat, en_cyc, we_cyc, other;
   int n_ack, idle_cyc, last_i, t1, t2;
   logic order [4];
   logic first_c, got_l;

   initial begin
      drive(PORT_C, 1'b0, 1'b0, '0, '0);
      drive(PORT_L, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_c_ack",     32'(bus.c_ack),     32'd0);
      check("rst_l_ack",     32'(bus.l_ack),     32'd0);
      check("rst_mem_en",    32'(bus.mem_en),    32'd0);
      check("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_rdata",     32'(bus.rdata),     32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      rst = 1'b0;
      @(negedge clk);

      // CPU read of address 3 (holds A5).
      run_txn(PORT_C, 1'b0, 5'd3, 8'h00, lat, en_cyc, we_cyc, other);
      check("rd_latency", 32'(lat), 32'd4);
      check("rd_en_cyc",  32'(en_cyc), 32'd3);
      check("rd_we_cyc",  32'(we_cyc), 32'd0);
      check("rd_l_ack",   32'(other), 32'd0);
      check("rd_rdata",   32'(bus.rdata), 32'hA5);
      @(negedge clk);

      // Loader write of 3C to address 10; rdata must not move.
      run_txn(PORT_L, 1'b1, 5'd10, 8'h3C, lat, en_cyc, we_cyc, other);
      check("wr_latency",  32'(lat), 32'd4);
      check("wr_en_cyc",   32'(en_cyc), 32'd3);
      check("wr_we_cyc",   32'(we_cyc), 32'd3);
      check("wr_c_ack",    32'(other), 32'd0);
      check("wr_rdata",    32'(bus.rdata), 32'hA5);
      check("wr_addr_ret", 32'(bus.mem_addr), 32'd10);
      check("wr_data_ret", 32'(bus.mem_wdata), 32'h3C);
      @(negedge clk);

      // Both ports hold requests from reset: grants must alternate starting with C.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(PORT_C, 1'b1, 1'b0, 5'd1, 8'h00);
      drive(PORT_L, 1'b1, 1'b0, 5'd2, 8'h00);
      n_ack = 0; idle_cyc = 0; last_i = -1;
      for (int i = 1; i <= 40 && n_ack < 4; i++) begin
         @(negedge clk);
         if (!bus.busy) idle_cyc++;
         if (bus.c_ack || bus.l_ack) begin
            order[n_ack] = bus.l_ack;
            n_ack++;
            last_i = i;
         end
      end
      drive(PORT_C, 1'b0, 1'b0, '0, '0);
      drive(PORT_L, 1'b0, 1'b0, '0, '0);
      check("tie_acks", 32'(n_ack), 32'd4);
      for (int k = 0; k < 4; k++) check("tie_order", 32'(order[k]), 32'(k % 2));
      check("tie_idle_gaps", 32'(idle_cyc), 32'd3);
      check("tie_span", 32'(last_i), 32'd19);
      @(negedge clk);

      // Request dropped during ACCESS still completes exactly once.
      drive(PORT_C, 1'b1, 1'b0, 5'd7, 8'h00);
      n_ack = 0; en_cyc = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 1) bus.c_req = 1'b0;
         if (bus.c_ack) n_ack++;
         if (bus.mem_en) en_cyc++;
      end
      check("drop_acks", 32'(n_ack), 32'd1);
      check("drop_en_cyc", 32'(en_cyc), 32'd3);

      // Reset in the middle of a write aborts it; the next tie goes to C.
      drive(PORT_L, 1'b1, 1'b1, 5'd12, 8'h5A);
      @(negedge clk);
      drive(PORT_C, 1'b1, 1'b0, 5'd4, 8'h00);
      rst = 1'b1;
      #1;
      check("abort_mem_en", 32'(bus.mem_en), 32'd0);
      check("abort_mem_we", 32'(bus.mem_we), 32'd0);
      check("abort_busy",   32'(bus.busy),   32'd0);
      check("abort_c_ack",  32'(bus.c_ack),  32'd0);
      check("abort_l_ack",  32'(bus.l_ack),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      first_c = 1'b0; n_ack = 0;
      for (int i = 1; i <= 20 && n_ack == 0; i++) begin
         @(negedge clk);
         if (bus.c_ack || bus.l_ack) begin
            n_ack++;
            first_c = bus.c_ack;
         end
      end
      bus.c_req = 1'b0;
      check("abort_first_c", 32'(first_c), 32'd1);
      got_l = 1'b0;
      for (int i = 1; i <= 20 && !got_l; i++) begin
         @(negedge clk);
         if (bus.l_ack) got_l = 1'b1;
      end
      bus.l_req = 1'b0;
      check("abort_then_l", 32'(got_l), 32'd1);
      @(negedge clk);

      // CPU keeps req high past its ack: a second transaction follows immediately.
      drive(PORT_C, 1'b1, 1'b0, 5'd5, 8'h00);
      t1 = -1; t2 = -1;
      for (int i = 1; i <= 30 && t2 < 0; i++) begin
         @(negedge clk);
         if (bus.c_ack) begin
            if (t1 < 0) t1 = i;
            else t2 = i;
         end
      end
      bus.c_req = 1'b0;
      check("hold_first",   32'(t1), 32'd4);
      check("hold_spacing", 32'(t2 - t1), 32'd5);

      // Randomized requesters obeying the hold-until-ack rule.
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (bus.c_ack) begin
            if ($urandom_range(1, 0) == 1) rand_cmd(PORT_C);
            else bus.c_req = 1'b0;
         end else if (!bus.c_req && $urandom_range(3, 0) == 0) begin
            rand_cmd(PORT_C);
         end
         if (bus.l_ack) begin
            if ($urandom_range(1, 0) == 1) rand_cmd(PORT_L);
            else bus.l_req = 1'b0;
         end else if (!bus.l_req && $urandom_range(3, 0) == 0) begin
            rand_cmd(PORT_L);
         end
      end
      // Let any in-flight transaction drain, then stop requesting.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.c_ack) bus.c_req = 1'b0;
         if (bus.l_ack) bus.l_req = 1'b0;
      end
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
